regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised successor to the datapath register file. It holds 2^ADDR_W−1 storage registers of WIDTH bits, with the top index mapped to an external value (the PC). It provides two operand read ports and one debug read port, and adds three features:
- a per-register pending (scoreboard) bit for multi-cycle producers;
- an optional same-cycle write-to-read bypass;
- a sequential clear engine that zeroes the whole file on request.

It sits between the instruction decoder/controller and the ALU operand muxes.

## Interface
Parameters:
- WIDTH, 32, data width of every register and port.
- ADDR_W, 4, select width. The file has 2^ADDR_W indices, and index 2^ADDR_W−1 (TOP) is the external value.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- write_enable  in  1  write request.
- Destination_select  in  ADDR_W  write index.
- DATA  in  WIDTH  write data.
- Reg_top  in  WIDTH  external value returned for index TOP.
- Source_select_0, Source_select_1, Debug_Source_select  in  ADDR_W  read indices.
- out_0, out_1, Debug_out  out  WIDTH  read data.
- lock_enable  in  1  set the pending bit of lock_select.
- lock_select  in  ADDR_W  index to mark pending.
- pending_0, pending_1  out  1  pending bit of Source_select_0 and Source_select_1.
- clear_req  in  1  start the clear sequence.
- busy  out  1  clear engine active.
- clear_done  out  1  one-cycle pulse when the clear sequence finishes.
- write_dropped  out  1  one-cycle pulse when a write or lock was ignored because busy was high.

## Operation
- **Reset** (reset low, asynchronous): all storage registers are 0, all pending bits are 0, the FSM is in IDLE, the clear index is 0, and busy, clear_done and write_dropped are 0. Read outputs therefore show 0 for indices below TOP and Reg_top for TOP.
- **Reads** are combinational. Index TOP always returns Reg_top. Any other index returns the stored value.
- **Accepted write:** write_enable=1, FSM in IDLE and Destination_select≠TOP. The register is loaded with DATA and its pending bit is cleared. A write to TOP is silently ignored.
- **Lock:** lock_enable=1, FSM in IDLE and lock_select≠TOP. The pending bit is set. A lock to TOP is ignored, and the pending bit for TOP always reads 0.
- **Write and lock to the same index in the same cycle:** the data is written and the pending bit ends at 1, because the lock names a new producer.
- **Clear FSM:**
  - IDLE: clear_req=1 → CLEAR, with the index set to 0.
  - CLEAR: each cycle, reg[index] is set to 0 and pending[index] is cleared, then the index increments. When the index reaches TOP−1, that register is cleared on this edge, the FSM returns to IDLE and clear_done pulses.
  - busy = (state==CLEAR).
  - clear_req is ignored while in CLEAR.
- **While busy:** write_enable and lock_enable are not applied. If either is high, write_dropped pulses on the next edge. Reads stay live and show partially cleared contents.

## Timing
- Read latency is 0 cycles, combinational from the selects.
- A write is visible on the outputs from the cycle after the edge. With bypass enabled it is visible in the same cycle.
- A pending bit set or cleared at edge N is visible on pending_0/1 from cycle N. There is no bypass on pending.
- The clear sequence takes exactly 2^ADDR_W−1 cycles of busy. clear_done is high for one cycle, coincident with busy going low.
- Asserting reset mid-clear aborts the sequence immediately, and all outputs take their reset values.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Applies to each read port independently.
  - Condition: an accepted write is in progress and its Destination_select equals that port's select (not TOP).
  - That port outputs DATA combinationally in the same cycle.
  - Clear-engine writes are never bypassed.
- REGFILE_BYPASS_EN undefined: a read returns the pre-edge stored value until the next cycle.

## Test plan
- **Reset, then write.** Reset low, then high. Write 0xDEADBEEF to index 3. Expected: out_0 with select 3 reads 0 before the edge and 0xDEADBEEF after it. Select 15 returns Reg_top=0x00001000.
- **Bypass.**
  - With REGFILE_BYPASS_EN, write 0x12345678 to index 5 while Source_select_1=5: out_1 = 0x12345678 in the same cycle.
  - Without the macro: out_1 holds its old value for that cycle.
- **Scoreboard.**
  - Lock index 7: pending_0 (select 7) = 1 from the next cycle.
  - Write index 7: pending_0 = 0.
  - Simultaneous write and lock to 7: pending_0 stays 1 and the data is updated.
- **Clear.** Fill indices 0–14 with non-zero values and assert clear_req for one cycle. Expected: busy high for 15 cycles, clear_done pulses once, all indices 0–14 read 0, all pending bits are 0.
- **Dropped write.** Issue write_enable to index 2 at cycle 4 of a clear. Expected: write_dropped pulses and index 2 reads 0 after the clear completes.
- **Reset mid-clear.** Assert reset low at cycle 6 of a clear. Expected: busy drops immediately and clear_done never pulses. A new clear_req after reset release runs the full 15 cycles.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending bits, a sequential clear engine and a TOP index mapped
// to Reg_top. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_scoreboard #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              write_enable,
   input  logic [ADDR_W-1:0] Destination_select,
   input  logic [WIDTH-1:0]  DATA,
   input  logic [WIDTH-1:0]  Reg_top,
   input  logic [ADDR_W-1:0] Source_select_0,
   input  logic [ADDR_W-1:0] Source_select_1,
   input  logic [ADDR_W-1:0] Debug_Source_select,
   output logic [WIDTH-1:0]  out_0,
   output logic [WIDTH-1:0]  out_1,
   output logic [WIDTH-1:0]  Debug_out,
   input  logic              lock_enable,
   input  logic [ADDR_W-1:0] lock_select,
   output logic              pending_0,
   output logic              pending_1,
   input  logic              clear_req,
   output logic              busy,
   output logic              clear_done,
   output logic              write_dropped
);

   localparam int unsigned       N    = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] TOP  = ADDR_W'(N - 1);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 2);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] CLEAR = 1'b1;

   logic [0:0]        state_q;
   logic [ADDR_W-1:0] idx_q;
   logic [WIDTH-1:0]  regs_q [N];   // entry TOP is never written and stays zero
   logic [N-1:0]      pending_q;

   logic wr_acc;
   logic lk_acc;
   logic byp_0;
   logic byp_1;
   logic byp_dbg;

   assign busy   = (state_q == CLEAR);
   assign wr_acc = write_enable && (state_q == IDLE) && (Destination_select != TOP);
   assign lk_acc = lock_enable && (state_q == IDLE) && (lock_select != TOP);

`ifdef REGFILE_BYPASS_EN
   assign byp_0   = wr_acc && (Destination_select == Source_select_0);
   assign byp_1   = wr_acc && (Destination_select == Source_select_1);
   assign byp_dbg = wr_acc && (Destination_select == Debug_Source_select);
`else
   assign byp_0   = 1'b0;
   assign byp_1   = 1'b0;
   assign byp_dbg = 1'b0;
`endif

   assign out_0 = (Source_select_0 == TOP) ? Reg_top :
                  byp_0 ? DATA : regs_q[Source_select_0];
   assign out_1 = (Source_select_1 == TOP) ? Reg_top :
                  byp_1 ? DATA : regs_q[Source_select_1];
   assign Debug_out = (Debug_Source_select == TOP) ? Reg_top :
                      byp_dbg ? DATA : regs_q[Debug_Source_select];

   assign pending_0 = pending_q[Source_select_0];
   assign pending_1 = pending_q[Source_select_1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         idx_q         <= '0;
         clear_done    <= 1'b0;
         write_dropped <= 1'b0;
         pending_q     <= '0;
         for (int i = 0; i < N; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         clear_done    <= 1'b0;
         write_dropped <= busy && (write_enable || lock_enable);

         case (state_q)
            IDLE: begin
               if (clear_req) begin
                  state_q <= CLEAR;
                  idx_q   <= '0;
               end
            end
            CLEAR: begin
               if (idx_q == LAST) begin
                  state_q    <= IDLE;
                  clear_done <= 1'b1;
               end else begin
                  idx_q <= idx_q + ADDR_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase

         for (int i = 0; i < N - 1; i++) begin
            if (busy && (idx_q == ADDR_W'(i))) begin
               regs_q[i]    <= '0;
               pending_q[i] <= 1'b0;
            end else begin
               if (wr_acc && (Destination_select == ADDR_W'(i))) begin
                  regs_q[i] <= DATA;
               end
               // A lock in the same cycle as the write names a newer producer, so it wins.
               if (lk_acc && (lock_select == ADDR_W'(i))) begin
                  pending_q[i] <= 1'b1;
               end else if (wr_acc && (Destination_select == ADDR_W'(i))) begin
                  pending_q[i] <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard; expectations follow REGFILE_BYPASS_EN if it is defined.
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic        write_enable;
   logic [3:0]  Destination_select;
   logic [31:0] DATA;
   logic [31:0] Reg_top;
   logic [3:0]  Source_select_0;
   logic [3:0]  Source_select_1;
   logic [3:0]  Debug_Source_select;
   logic [31:0] out_0;
   logic [31:0] out_1;
   logic [31:0] Debug_out;
   logic        lock_enable;
   logic [3:0]  lock_select;
   logic        pending_0;
   logic        pending_1;
   logic        clear_req;
   logic        busy;
   logic        clear_done;
   logic        write_dropped;

   int checks = 0;
   int errors = 0;
   int busy_cnt;
   int done_cnt;
   int drop_cnt;

   always #5 clk = ~clk;

   regfile_scoreboard #(.WIDTH(32), .ADDR_W(4)) dut (
      .clk                 (clk),
      .reset               (reset),
      .write_enable        (write_enable),
      .Destination_select  (Destination_select),
      .DATA                (DATA),
      .Reg_top             (Reg_top),
      .Source_select_0     (Source_select_0),
      .Source_select_1     (Source_select_1),
      .Debug_Source_select (Debug_Source_select),
      .out_0               (out_0),
      .out_1               (out_1),
      .Debug_out           (Debug_out),
      .lock_enable         (lock_enable),
      .lock_select         (lock_select),
      .pending_0           (pending_0),
      .pending_1           (pending_1),
      .clear_req           (clear_req),
      .busy                (busy),
      .clear_done          (clear_done),
      .write_dropped       (write_dropped)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; write_enable = 1'b0; Destination_select = '0; DATA = '0;
      Reg_top = 32'h0000_1000; Source_select_0 = '0; Source_select_1 = '0;
      Debug_Source_select = 4'd15; lock_enable = 1'b0; lock_select = '0; clear_req = 1'b0;
      #12;
      check("rst_out0", out_0, 32'h0);
      check("rst_top", Debug_out, 32'h0000_1000);
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_done", {31'b0, clear_done}, 32'h0);
      check("rst_drop", {31'b0, write_dropped}, 32'h0);
      check("rst_pend", {31'b0, pending_0}, 32'h0);
      reset = 1'b1;
      step();

      // Reset, then write
      Source_select_0 = 4'd3; Source_select_1 = 4'd15;
      write_enable = 1'b1; Destination_select = 4'd3; DATA = 32'hDEAD_BEEF;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("wr3_pre", out_0, 32'hDEAD_BEEF);
`else
      check("wr3_pre", out_0, 32'h0);
`endif
      step();
      write_enable = 1'b0;
      #1;
      check("wr3_post", out_0, 32'hDEAD_BEEF);
      check("top_read", out_1, 32'h0000_1000);

      // Write to TOP is ignored; index 14 must remain untouched
      write_enable = 1'b1; Destination_select = 4'd15; DATA = 32'h1111_1111;
      Debug_Source_select = 4'd14;
      step();
      write_enable = 1'b0;
      #1;
      check("top_wr_ign", Debug_out, 32'h0);

      // Bypass
      Source_select_1 = 4'd5;
      write_enable = 1'b1; Destination_select = 4'd5; DATA = 32'h1234_5678;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("byp_same", out_1, 32'h1234_5678);
`else
      check("byp_same", out_1, 32'h0);
`endif
      step();
      write_enable = 1'b0;
      #1;
      check("byp_next", out_1, 32'h1234_5678);

      // Scoreboard
      Source_select_0 = 4'd7;
      lock_enable = 1'b1; lock_select = 4'd7;
      #1;
      check("lock_pre", {31'b0, pending_0}, 32'h0);
      step();
      lock_enable = 1'b0;
      #1;
      check("lock_post", {31'b0, pending_0}, 32'h1);
      write_enable = 1'b1; Destination_select = 4'd7; DATA = 32'h0000_00AA;
      step();
      write_enable = 1'b0;
      #1;
      check("wr_unlock", {31'b0, pending_0}, 32'h0);
      check("wr7_data", out_0, 32'h0000_00AA);
      write_enable = 1'b1; lock_enable = 1'b1; DATA = 32'h0000_00BB;
      step();
      write_enable = 1'b0; lock_enable = 1'b0;
      #1;
      check("wrlk_pend", {31'b0, pending_0}, 32'h1);
      check("wrlk_data", out_0, 32'h0000_00BB);
      lock_enable = 1'b1; lock_select = 4'd15; Source_select_1 = 4'd15;
      step();
      lock_enable = 1'b0;
      #1;
      check("lock_top", {31'b0, pending_1}, 32'h0);

      // Fill, lock one index, then clear with a dropped write at cycle 4
      for (int i = 0; i < 15; i++) begin
         write_enable = 1'b1; Destination_select = 4'(i); DATA = 32'(i + 1);
         step();
      end
      write_enable = 1'b0;
      lock_enable = 1'b1; lock_select = 4'd9;
      step();
      lock_enable = 1'b0;
      Source_select_0 = 4'd9;
      #1;
      check("fill_pend9", {31'b0, pending_0}, 32'h1);
      Source_select_0 = 4'd0; Debug_Source_select = 4'd14;
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      busy_cnt = 0; done_cnt = 0; drop_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (busy) busy_cnt++;
         if (clear_done) begin
            done_cnt++;
            check("done_busy_lo", {31'b0, busy}, 32'h0);
         end
         if (write_dropped) drop_cnt++;
         if (k == 3) begin
            check("mid_clr0", out_0, 32'h0);
            check("mid_keep14", Debug_out, 32'd15);
            write_enable = 1'b1; Destination_select = 4'd2; DATA = 32'h5555_5555;
         end
         if (k == 4) begin
            check("drop_pulse", {31'b0, write_dropped}, 32'h1);
            write_enable = 1'b0;
         end
         step();
      end
      check("clr_busy_cnt", busy_cnt, 32'd15);
      check("clr_done_cnt", done_cnt, 32'd1);
      check("drop_cnt", drop_cnt, 32'd1);
      for (int i = 0; i < 15; i++) begin
         Debug_Source_select = 4'(i); Source_select_0 = 4'(i);
         #1;
         check($sformatf("clr_val%0d", i), Debug_out, 32'h0);
         check($sformatf("clr_pend%0d", i), {31'b0, pending_0}, 32'h0);
      end

      // Reset mid-clear
      write_enable = 1'b1; Destination_select = 4'd13; DATA = 32'h0000_0044;
      step();
      write_enable = 1'b0;
      Debug_Source_select = 4'd13;
      #1;
      check("pre_abort13", Debug_out, 32'h0000_0044);
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      for (int k = 0; k < 5; k++) step();
      check("abort_busy_pre", {31'b0, busy}, 32'h1);
      reset = 1'b0;
      #1;
      check("abort_busy", {31'b0, busy}, 32'h0);
      check("abort_done", {31'b0, clear_done}, 32'h0);
      check("abort_val13", Debug_out, 32'h0);
      #3;
      reset = 1'b1;
      done_cnt = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         if (clear_done) done_cnt++;
      end
      check("abort_no_done", done_cnt, 32'd0);
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      busy_cnt = 0; done_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (busy) busy_cnt++;
         if (clear_done) done_cnt++;
         step();
      end
      check("reclr_busy_cnt", busy_cnt, 32'd15);
      check("reclr_done_cnt", done_cnt, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
